// File: rtl/bird_motion.sv
// bird_motion: per-frame vertical motion for the player sprite.
// Fixed-point Q12.4 position and Q6.4 velocity advance once per video frame.
// A four-state life cycle (IDLE/FLY/FALL/DEAD) decides which forces apply.
module bird_motion #(
  parameter int X_POS    = 320,
  parameter int Y_START  = 360,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 680,
  parameter int GRAVITY  = 6,
  parameter int FLAP_VEL = -96,
  parameter int VMAX     = 160
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic               RGB_VSync,
  input  logic               flap,
  input  logic               start,
  input  logic               game_over,
  output logic [11:0]        bpos_x,
  output logic [11:0]        bpos_y,
  output logic signed [9:0]  vel,
  output logic [1:0]         bird_state,
  output logic               crashed
);

  typedef enum logic [1:0] {IDLE = 2'd0, FLY = 2'd1, FALL = 2'd2, DEAD = 2'd3} state_t;

  localparam logic [15:0]        POS_START = 16'(Y_START * 16);
  localparam logic [15:0]        POS_MIN   = 16'(Y_MIN * 16);
  localparam logic [15:0]        POS_MAX   = 16'(Y_MAX * 16);
  localparam logic signed [16:0] P_MIN     = 17'(Y_MIN * 16);
  localparam logic signed [16:0] P_MAX     = 17'(Y_MAX * 16);
  localparam logic signed [9:0]  FLAP_V    = 10'(FLAP_VEL);
  localparam logic signed [9:0]  VMAX_V    = 10'(VMAX);
  localparam logic signed [10:0] VMAX_W    = 11'(VMAX);
  localparam logic signed [10:0] GRAV_W    = 11'(GRAVITY);

  state_t             state;
  logic [15:0]        pos;
  logic signed [9:0]  vel_r;
  logic               flap_pend;
  logic               vs_q;
  logic               tick_q;

  logic signed [10:0] vel_g;
  logic signed [9:0]  vel_n;
  logic signed [16:0] p;

  // Next-frame velocity and candidate position; 11/17-bit signed so the
  // gravity add cannot overflow and a negative position cannot wrap.
  always_comb begin
    vel_g = 11'({vel_r[9], vel_r}) + GRAV_W;
    vel_n = (vel_g > VMAX_W) ? VMAX_V : vel_g[9:0];
    // A flap landing in the tick cycle still counts for that tick.
    if (state == FLY && (flap_pend || flap))
      vel_n = FLAP_V;
    p = $signed({1'b0, pos}) + $signed({{7{vel_n[9]}}, vel_n});
  end

  // Frame tick, flap latch and life-cycle FSM with registered outputs.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      pos       <= POS_START;
      vel_r     <= '0;
      flap_pend <= 1'b0;
      vs_q      <= 1'b1;  // no spurious tick if VSync is high at release
      tick_q    <= 1'b0;
      crashed   <= 1'b0;
    end else begin
      vs_q   <= RGB_VSync;
      tick_q <= RGB_VSync & ~vs_q;
      if (tick_q) flap_pend <= 1'b0;
      case (state)
        IDLE: begin
          pos   <= POS_START;
          vel_r <= '0;
          if (flap) begin
            state     <= FLY;
            flap_pend <= 1'b1;
          end
        end
        FLY: begin
          if (game_over) begin
            // game_over outranks any flap in the same cycle
            state     <= FALL;
            vel_r     <= '0;
            flap_pend <= 1'b0;
          end else if (tick_q) begin
            if (p < P_MIN) begin
              pos   <= POS_MIN;
              vel_r <= '0;
            end else if (p >= P_MAX) begin
              pos     <= POS_MAX;
              vel_r   <= '0;
              state   <= DEAD;
              crashed <= 1'b1;
            end else begin
              pos   <= p[15:0];
              vel_r <= vel_n;
            end
          end else if (flap) begin
            flap_pend <= 1'b1;
          end
        end
        FALL: begin
          flap_pend <= 1'b0;
          if (tick_q) begin
            if (p < P_MIN) begin
              pos   <= POS_MIN;
              vel_r <= '0;
            end else if (p >= P_MAX) begin
              pos     <= POS_MAX;
              vel_r   <= '0;
              state   <= DEAD;
              crashed <= 1'b1;
            end else begin
              pos   <= p[15:0];
              vel_r <= vel_n;
            end
          end
        end
        DEAD: begin
          flap_pend <= 1'b0;
          if (start) begin
            state   <= IDLE;
            pos     <= POS_START;
            vel_r   <= '0;
            crashed <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bpos_x     = 12'(X_POS);
  assign bpos_y     = pos[15:4];
  assign vel        = vel_r;
  assign bird_state = state;

endmodule

// File: tb/tb_bird_motion.sv
// tb_bird_motion: scoreboard bench for bird_motion with a behavioural
// reference model; each frame pushes the expected result on VSync rise and
// pops it when the update is due.
module tb_bird_motion;

  logic              clk = 1'b0;
  logic              Rst;
  logic              RGB_VSync, flap, start, game_over;
  logic [11:0]       bpos_x, bpos_y;
  logic signed [9:0] vel;
  logic [1:0]        bird_state;
  logic              crashed;

  bird_motion dut (
    .clk(clk), .Rst(Rst), .RGB_VSync(RGB_VSync), .flap(flap), .start(start),
    .game_over(game_over), .bpos_x(bpos_x), .bpos_y(bpos_y), .vel(vel),
    .bird_state(bird_state), .crashed(crashed)
  );

  always #5 clk = ~clk;

  typedef struct { int st; int y; int v; int cr; } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int m_pos, m_vel, m_st, m_pend, m_cr;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_st"}, int'(bird_state), m_st);
    chk({tag, "_y"},  int'(bpos_y), m_pos / 16);
    chk({tag, "_v"},  int'(vel), m_vel);
    chk({tag, "_cr"}, int'(crashed), m_cr);
    chk({tag, "_x"},  int'(bpos_x), 320);
  endtask

  task automatic m_reset();
    m_st = 0; m_pos = 360 * 16; m_vel = 0; m_pend = 0; m_cr = 0;
    sb.delete();
  endtask

  task automatic m_flap();
    if (m_st == 0) begin m_st = 1; m_pend = 1; end
    else if (m_st == 1) m_pend = 1;
  endtask

  task automatic m_tick();
    int vn, p;
    if (m_st == 1 || m_st == 2) begin
      if (m_st == 1 && m_pend != 0) vn = -96;
      else begin
        vn = m_vel + 6;
        if (vn > 160) vn = 160;
      end
      p = m_pos + vn;
      if (p < 0) begin m_pos = 0; m_vel = 0; end
      else if (p >= 680 * 16) begin m_pos = 680 * 16; m_vel = 0; m_st = 3; m_cr = 1; end
      else begin m_pos = p; m_vel = vn; end
    end
    m_pend = 0;
  endtask

  task automatic pulse_flap();
    @(negedge clk) flap = 1'b1;
    m_flap();
    @(negedge clk) flap = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    if (m_st == 3) begin m_st = 0; m_pos = 360 * 16; m_vel = 0; m_cr = 0; end
    @(negedge clk) start = 1'b0;
  endtask

  task automatic raise_go();
    @(negedge clk) game_over = 1'b1;
    if (m_st == 1) begin m_st = 2; m_vel = 0; m_pend = 0; end
  endtask

  // One video frame: VSync low, optional flap, VSync rise; result due two
  // edges after VSync is first sampled high.
  task automatic frame(input bit fl);
    exp_t e, o;
    int old_y;
    @(negedge clk) RGB_VSync = 1'b0;
    repeat (3) @(negedge clk);
    if (fl) pulse_flap();
    @(negedge clk) RGB_VSync = 1'b1;
    old_y = m_pos / 16;
    m_tick();
    e.st = m_st; e.y = m_pos / 16; e.v = m_vel; e.cr = m_cr;
    sb.push_back(e);
    @(posedge clk); #1;
    chk("lat_y", int'(bpos_y), old_y);
    @(posedge clk); #1;
    o = sb.pop_front();
    chk("sb_st", int'(bird_state), o.st);
    chk("sb_y",  int'(bpos_y), o.y);
    chk("sb_v",  int'(vel), o.v);
    chk("sb_cr", int'(crashed), o.cr);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ey[3];
    int ev[3];
    ey = '{354, 348, 343};
    ev = '{-96, -90, -84};

    Rst = 1'b0; RGB_VSync = 1'b1; flap = 1'b0; start = 1'b0; game_over = 1'b0;
    m_reset();
    #12;
    chk_all("rst");
    @(negedge clk) Rst = 1'b1;

    // idle frames: nothing moves
    repeat (10) frame(0);
    chk_all("idle10");

    // reset again with VSync high across release, then flap: no spurious tick
    @(negedge clk) Rst = 1'b0;
    m_reset();
    RGB_VSync = 1'b1;
    @(negedge clk) Rst = 1'b1;
    pulse_flap();
    repeat (4) @(negedge clk);
    chk_all("nospur");

    // first three flight frames
    for (int i = 0; i < 3; i++) begin
      frame(0);
      chk("fly_y", int'(bpos_y), ey[i]);
      chk("fly_v", int'(vel), ev[i]);
    end

    // ceiling: keep flapping until clamped at the top
    repeat (60) frame(1);
    chk("ceil_y", int'(bpos_y), 0);
    chk("ceil_v", int'(vel), 0);
    chk("ceil_st", int'(bird_state), 1);

    // free fall from vel 0 at the ceiling: saturate on tick 27
    for (int i = 1; i <= 27; i++) begin
      frame(0);
      if (i == 26) chk("ff_v26", int'(vel), 156);
    end
    chk("ff_v27", int'(vel), 160);
    chk("ff_y27", int'(bpos_y), 141);
    frame(0);
    chk("ff_v28", int'(vel), 160);
    chk("ff_y28", int'(bpos_y), 151);

    // start outside DEAD is ignored
    pulse_start();
    chk_all("start_ign");

    // game_over and flap in the same cycle
    @(negedge clk);
    game_over = 1'b1; flap = 1'b1;
    if (m_st == 1) begin m_st = 2; m_vel = 0; m_pend = 0; end
    @(negedge clk) flap = 1'b0;
    @(negedge clk);
    chk("go_st", int'(bird_state), 2);
    chk("go_v", int'(vel), 0);
    chk("go_y", int'(bpos_y), 151);

    // fall to the ground, flaps ignored on the way
    for (int i = 0; i < 80 && m_st != 3; i++) frame(i[0]);
    chk("gnd_y", int'(bpos_y), 680);
    chk("gnd_st", int'(bird_state), 3);
    chk("gnd_cr", int'(crashed), 1);
    frame(1);
    chk_all("dead_frozen");

    // restart
    @(negedge clk) game_over = 1'b0;
    pulse_start();
    @(negedge clk);
    chk("rs_st", int'(bird_state), 0);
    chk("rs_y", int'(bpos_y), 360);
    chk("rs_v", int'(vel), 0);
    chk("rs_cr", int'(crashed), 0);

    // async reset mid-FALL, between edges
    pulse_flap();
    frame(0);
    frame(0);
    raise_go();
    repeat (3) frame(0);
    chk("pre_rst_st", int'(bird_state), 2);
    @(posedge clk); #2;
    Rst = 1'b0;
    m_reset();
    #1;
    chk_all("async_rst");
    @(negedge clk) Rst = 1'b1;
    game_over = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
